// File: rtl/half_min_reduce.sv
// half_min_reduce: per-group streaming IEEE-754 minimum with winner index, count, NaN and overflow flags.
module half_min_reduce #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    IDX_BITS  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [BITS-1:0]     a,
    output logic                out_valid,
    output logic [BITS-1:0]     out_min,
    output logic [IDX_BITS-1:0] out_idx,
    output logic [IDX_BITS-1:0] out_count,
    output logic                out_nan,
    output logic                out_ovf
);
    localparam int EXP = (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MAN = BITS - 1 - EXP;
    localparam logic [IDX_BITS-1:0] MAX = '1;

    if (!(PRECISION == "HALF" && BITS == 16) && !(PRECISION == "SINGLE" && BITS == 32)) begin : g_bad_cfg
        $error("half_min_reduce: PRECISION must be HALF (BITS=16) or SINGLE (BITS=32)");
    end

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state;
    logic [BITS-1:0]     run_min;
    logic [IDX_BITS-1:0] run_idx, run_cnt;
    logic                run_nan, run_ovf;

    logic [BITS-1:0]     nxt_min;
    logic [IDX_BITS-1:0] nxt_idx, nxt_cnt;
    logic                nxt_nan, nxt_ovf, first, sat, nan_a, take;

    // Mapping sign-magnitude onto an unsigned key gives the total order, with -0 just below +0.
    function automatic logic [BITS-1:0] key(input logic [BITS-1:0] v);
        return v[BITS-1] ? ~v : {1'b1, v[BITS-2:0]};
    endfunction

    function automatic logic is_nan(input logic [BITS-1:0] v);
        return (&v[BITS-2 -: EXP]) && (|v[MAN-1:0]);
    endfunction

    always_comb begin
        first   = state == IDLE;
        sat     = run_cnt == MAX;
        nan_a   = is_nan(a);
        take    = first || (!nan_a && (is_nan(run_min) || key(a) < key(run_min)));
        nxt_min = take ? a : run_min;
        nxt_idx = first ? '0 : (take ? run_cnt : run_idx);
        nxt_cnt = first ? IDX_BITS'(1) : (sat ? run_cnt : run_cnt + IDX_BITS'(1));
        nxt_nan = nan_a || (!first && run_nan);
        nxt_ovf = !first && (run_ovf || sat);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            run_min   <= '0;
            run_idx   <= '0;
            run_cnt   <= '0;
            run_nan   <= 1'b0;
            run_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_nan   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= in_valid && in_last;
            if (in_valid) begin
                state   <= in_last ? IDLE : ACCUM;
                run_min <= nxt_min;
                run_idx <= nxt_idx;
                run_cnt <= nxt_cnt;
                run_nan <= nxt_nan;
                run_ovf <= nxt_ovf;
                if (in_last) begin
                    out_min   <= nxt_min;
                    out_idx   <= nxt_idx;
                    out_count <= nxt_cnt;
                    out_nan   <= nxt_nan;
                    out_ovf   <= nxt_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_half_min_reduce.sv
// tb_half_min_reduce: scoreboard bench driving two widths of half_min_reduce against a group-level reference model.
module tb_half_min_reduce;
    typedef struct packed {
        logic [15:0] mn;
        logic [7:0]  idx;
        logic [7:0]  cnt;
        logic        nan;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [15:0] a = '0;
    logic        started = 1'b0;

    logic        ov8, nan8, ovf8, ov2, nan2, ovf2;
    logic [15:0] min8, min2;
    logic [7:0]  idx8, cnt8;
    logic [1:0]  idx2, cnt2;

    int checks = 0, errors = 0;
    res_t q8[$], q2[$];
    logic [15:0] grp[$];
    logic [15:0] prev = 16'h3C00;
    res_t held8 = '0, held2 = '0;

    half_min_reduce #(.BITS(16), .PRECISION("HALF"), .IDX_BITS(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last), .a(a),
        .out_valid(ov8), .out_min(min8), .out_idx(idx8), .out_count(cnt8), .out_nan(nan8), .out_ovf(ovf8)
    );

    half_min_reduce #(.BITS(16), .PRECISION("HALF"), .IDX_BITS(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last), .a(a),
        .out_valid(ov2), .out_min(min2), .out_idx(idx2), .out_count(cnt2), .out_nan(nan2), .out_ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic nan16(input logic [15:0] v);
        return v[14:10] == 5'h1f && v[9:0] != 0;
    endfunction

    function automatic logic below(input logic [15:0] x, input logic [15:0] y);
        if (x[15] != y[15]) return x[15];
        if (x[15]) return x[14:0] > y[14:0];
        return x[14:0] < y[14:0];
    endfunction

    function automatic res_t model(input int maxc);
        res_t r;
        int win = -1;
        int n = grp.size();
        r = '0;
        foreach (grp[i]) begin
            if (nan16(grp[i])) r.nan = 1'b1;
            else if (win < 0 || below(grp[i], grp[win])) win = i;
        end
        if (win < 0) win = 0;
        r.mn  = grp[win];
        r.idx = 8'((win > maxc) ? maxc : win);
        r.cnt = 8'((n > maxc) ? maxc : n);
        r.ovf = n > maxc;
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic [15:0] d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last = l;
        a = d;
        if (v) begin
            grp.push_back(d);
            if (l) begin
                q8.push_back(model(255));
                q2.push_back(model(3));
                grp.delete();
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        grp.delete();
        #1;
        check("reset_outputs8", {ov8, min8, idx8, cnt8, nan8, ovf8}, '0);
        check("reset_outputs2", {ov2, min2, idx2, cnt2, nan2, ovf2}, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        started = 1'b1;
    endtask

    function automatic logic [15:0] rv();
        logic [15:0] v;
        int sel = $urandom_range(0, 9);
        logic [15:0] sp[4] = '{16'h7C00, 16'hFC00, 16'h0000, 16'h8000};
        v = sel == 0 ? sp[$urandom_range(0, 3)] :
            sel == 1 ? (16'h7C01 | 16'($urandom_range(0, 1023)) | {$urandom_range(0, 1) == 1, 15'h0}) :
            sel == 2 ? prev : 16'($urandom);
        prev = v;
        return v;
    endfunction

    always @(negedge clk) begin
        res_t act8, act2;
        act8 = {min8, idx8, cnt8, nan8, ovf8};
        act2 = {min2, 6'b0, idx2, 6'b0, cnt2, nan2, ovf2};
        if (started && rstn) begin
            if (ov8) begin
                check("result_pending8", q8.size() != 0, 1);
                if (q8.size() != 0) begin
                    held8 = q8.pop_front();
                    check("result8", act8, held8);
                end
            end else check("hold8", act8, held8);
            if (ov2) begin
                check("result_pending2", q2.size() != 0, 1);
                if (q2.size() != 0) begin
                    held2 = q2.pop_front();
                    check("result2", act2, held2);
                end
            end else check("hold2", act2, held2);
        end else begin
            held8 = '0;
            held2 = '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] g1[4] = '{16'h4200, 16'h3C00, 16'hC000, 16'h4000};
        logic [15:0] g2[3] = '{16'h7E00, 16'h4000, 16'h7E00};
        do_reset();
        foreach (g1[i]) drive(1'b1, i == 3, g1[i]);
        drive(1'b1, 1'b0, 16'h3C00);
        drive(1'b1, 1'b1, 16'h3C00);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 16'h8000);
        foreach (g2[i]) drive(1'b1, i == 2, g2[i]);
        drive(1'b1, 1'b1, 16'h7E00);
        drive(1'b1, 1'b0, 16'hC000);
        drive(1'b1, 1'b0, 16'h3C00);
        do_reset();
        drive(1'b1, 1'b1, 16'h4400);
        drive(1'b1, 1'b1, 16'h4000);
        drive(1'b1, 1'b0, 16'h3800);
        drive(1'b1, 1'b1, 16'hBC00);
        drive(1'b1, 1'b0, 16'h4200);
        drive(1'b0, 1'b1, 16'h0000);
        drive(1'b1, 1'b0, 16'h3C00);
        drive(1'b0, 1'b0, 16'hFC00);
        drive(1'b0, 1'b1, 16'h8000);
        drive(1'b1, 1'b1, 16'hC000);
        repeat (4) drive(1'b1, 1'b0, 16'h4000);
        drive(1'b1, 1'b1, 16'h3C00);
        for (int i = 0; i < 260; i++) drive(1'b1, i == 259, i == 258 ? 16'hFC00 : 16'h5000);
        for (int g = 0; g < 300; g++) begin
            int n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 99) == 0) do_reset();
                while ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
                drive(1'b1, i == n - 1, rv());
            end
        end
        repeat (3) drive(1'b0, 1'b0, 16'h0);
        check("drained8", q8.size(), 0);
        check("drained2", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
